// File: rtl/sonic_sensor_sched.sv
// sonic_sensor_sched: shares one sonic range sensor between four requesters.
// A round-robin arbiter grants the sensor, the scheduler triggers it, waits
// for the measurement under two timeouts, returns the echo width to the owner
// and then holds off for a guard time so stale echoes die out.
// Optional feature: define SONIC_SCHED_AUTO_EN to add a lowest-priority
// internal requester that pings every AUTO_PERIOD cycles and only refreshes
// last_data.
// All timing parameters must be at least 1.
module sonic_sensor_sched #(
  parameter int unsigned START_WAIT  = 16,
  parameter int unsigned MEAS_TO     = 2000000,
  parameter int unsigned GUARD_CYC   = 500000,
  parameter int unsigned AUTO_PERIOD = 10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_valid,
  output logic [3:0]  grant,
  output logic [3:0]  resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        sns_start,
  input  logic        sns_busy,
  input  logic [31:0] sns_data,
  output logic [31:0] last_data,
  output logic        sched_busy
);

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    START,
    WAIT_BUSY,
    MEASURE,
    DONE,
    GUARD
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [31:0] cnt_sat;
  logic [1:0]  rr_ptr;
  logic        auto_active;
  logic        auto_pend;
  logic        pick_found;
  logic [1:0]  pick_idx;
  logic [1:0]  cand;

  // Shared timeout counter increments but never wraps.
  assign cnt_sat = (cnt == '1) ? cnt : cnt + 32'd1;

  // Round-robin pick: first asserted request at or after rr_ptr.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr;
    cand       = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = rr_ptr + 2'(i);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

`ifdef SONIC_SCHED_AUTO_EN
  logic [31:0] auto_cnt;
  logic        auto_take;

  // Auto ping is taken only when no external requester wins arbitration.
  assign auto_take = (state == ARB) && !pick_found && auto_pend;

  // Auto-ping period counter, running only while the sensor is not in use.
  always_ff @(posedge clk) begin
    if (rst) begin
      auto_cnt  <= '0;
      auto_pend <= 1'b0;
    end else if (auto_take) begin
      auto_pend <= 1'b0;
    end else if (!auto_pend && (state == IDLE || state == GUARD)) begin
      if (auto_cnt >= AUTO_PERIOD - 1) begin
        auto_cnt  <= '0;
        auto_pend <= 1'b1;
      end else begin
        auto_cnt <= auto_cnt + 32'd1;
      end
    end
  end
`else
  logic unused_auto_period;

  assign auto_pend          = 1'b0;
  assign unused_auto_period = |AUTO_PERIOD;
`endif

  // Scheduler FSM with registered outputs; every state entry clears cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rr_ptr      <= '0;
      grant       <= '0;
      resp_valid  <= '0;
      resp_data   <= '0;
      resp_err    <= 1'b0;
      sns_start   <= 1'b0;
      last_data   <= '0;
      sched_busy  <= 1'b0;
      auto_active <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid != '0 || auto_pend) begin
            state      <= ARB;
            cnt        <= '0;
            sched_busy <= 1'b1;
          end
        end

        ARB: begin
          cnt <= '0;
          if (pick_found) begin
            grant       <= 4'b0001 << pick_idx;
            rr_ptr      <= pick_idx + 2'd1;
            auto_active <= 1'b0;
            sns_start   <= 1'b1;
            state       <= START;
          end else if (auto_pend) begin
            auto_active <= 1'b1;
            sns_start   <= 1'b1;
            state       <= START;
          end else begin
            // Request vanished before arbitration: nothing to do.
            state      <= IDLE;
            sched_busy <= 1'b0;
          end
        end

        START: begin
          sns_start <= 1'b0;
          cnt       <= '0;
          state     <= WAIT_BUSY;
        end

        WAIT_BUSY: begin
          if (sns_busy) begin
            cnt   <= '0;
            state <= MEASURE;
          end else if (cnt >= START_WAIT - 1) begin
            cnt   <= '0;
            state <= DONE;
            if (!auto_active) begin
              resp_valid <= grant;
              resp_data  <= '1;
              resp_err   <= 1'b1;
            end
          end else begin
            cnt <= cnt_sat;
          end
        end

        MEASURE: begin
          if (!sns_busy) begin
            cnt       <= '0;
            state     <= DONE;
            last_data <= sns_data;
            if (!auto_active) begin
              resp_valid <= grant;
              resp_data  <= sns_data;
              resp_err   <= 1'b0;
            end
          end else if (cnt >= MEAS_TO - 1) begin
            cnt   <= '0;
            state <= DONE;
            if (!auto_active) begin
              resp_valid <= grant;
              resp_data  <= '1;
              resp_err   <= 1'b1;
            end
          end else begin
            cnt <= cnt_sat;
          end
        end

        DONE: begin
          // Response fields are only meaningful during the resp_valid pulse.
          resp_valid  <= '0;
          resp_data   <= '0;
          resp_err    <= 1'b0;
          grant       <= '0;
          auto_active <= 1'b0;
          cnt         <= '0;
          state       <= GUARD;
        end

        GUARD: begin
          if (cnt >= GUARD_CYC - 1) begin
            cnt        <= '0;
            state      <= IDLE;
            sched_busy <= 1'b0;
          end else begin
            cnt <= cnt_sat;
          end
        end

        default: begin
          cnt        <= '0;
          state      <= IDLE;
          sched_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
